// File: rtl/tdc_sample_stats.sv
// Block statistics over 2^LOG2_N TDC count samples: average always, and min/max/range
// when built with TDC_STATS_MINMAX_EN. One statistic is selected onto result under a valid/ready handshake.
module tdc_sample_stats #(
  parameter int LOG2_N = 4,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic [1:0]       stat_sel,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int ACC_W = WIDTH + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] avg_q;
  logic             accept;
  logic             last_sample;

  logic [WIDTH-1:0] stat_min;
  logic [WIDTH-1:0] stat_max;
  logic [WIDTH-1:0] stat_rng;

  assign accept      = (state == ACCUM) && sample_valid;
  assign last_sample = accept && (cnt == LAST_CNT);
  // The accumulator is WIDTH+LOG2_N bits, so the full block sum can never wrap.
  assign acc_sum     = acc + ACC_W'(sample_in);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state takes a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (last_sample) state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      avg_q <= '0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_sum;
      cnt <= cnt + CNT_W'(1);
      if (last_sample) avg_q <= WIDTH'(acc_sum >> LOG2_N);
    end
  end

`ifdef TDC_STATS_MINMAX_EN
  logic [WIDTH-1:0] min_r, max_r, min_q, max_q;
  logic [WIDTH-1:0] min_nxt, max_nxt;

  assign min_nxt = (sample_in < min_r) ? sample_in : min_r;
  assign max_nxt = (sample_in > max_r) ? sample_in : max_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_r <= '0;
      max_r <= '0;
      min_q <= '0;
      max_q <= '0;
    end else if (state == IDLE && start) begin
      min_r <= '1;
      max_r <= '0;
    end else if (accept) begin
      min_r <= min_nxt;
      max_r <= max_nxt;
      if (last_sample) begin
        min_q <= min_nxt;
        max_q <= max_nxt;
      end
    end
  end

  // min_q <= max_q whenever both come from the same block (or both are reset), so no underflow.
  assign stat_min = min_q;
  assign stat_max = max_q;
  assign stat_rng = max_q - min_q;
`else
  assign stat_min = '0;
  assign stat_max = '0;
  assign stat_rng = '0;
`endif

  // Output mux draws only on registers, so result cannot glitch relative to clk.
  always_comb begin
    result = avg_q;
    unique case (stat_sel)
      2'b00: result = avg_q;
      2'b01: result = stat_min;
      2'b10: result = stat_max;
      2'b11: result = stat_rng;
      default: result = avg_q;
    endcase
  end

endmodule

// File: tb/tb_tdc_sample_stats.sv
// Directed self-checking bench for tdc_sample_stats (LOG2_N=4); expectations for the
// min/max/range selections follow TDC_STATS_MINMAX_EN.
module tb_tdc_sample_stats;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [1:0] stat_sel;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       busy;

  int total = 0;
  int bad   = 0;

  tdc_sample_stats #(.LOG2_N(4), .WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .stat_sel     (stat_sel),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag, input logic [7:0] e_avg,
                             input logic [7:0] e_min, input logic [7:0] e_max,
                             input logic [7:0] e_rng);
    logic [7:0] m, x, r;
`ifdef TDC_STATS_MINMAX_EN
    m = e_min; x = e_max; r = e_rng;
`else
    m = 8'h00; x = 8'h00; r = 8'h00;
`endif
    stat_sel = 2'b00; #1; check({tag, ".avg"}, result, e_avg);
    stat_sel = 2'b01; #1; check({tag, ".min"}, result, m);
    stat_sel = 2'b10; #1; check({tag, ".max"}, result, x);
    stat_sel = 2'b11; #1; check({tag, ".rng"}, result, r);
    stat_sel = 2'b00;
  endtask

  // Sample_valid is held high with a junk value on the start cycle; it must be ignored.
  task automatic pulse_start();
    start = 1'b1; sample_valid = 1'b1; sample_in = 8'hFF;
    tick();
    start = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic feed(input logic [7:0] v, input bit gap);
    sample_valid = 1'b1; sample_in = v;
    tick();
    sample_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic accept_result(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, ".rv_low"}, result_valid, 1'b0);
    check({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sample_in = 8'h00; sample_valid = 1'b0;
    stat_sel = 2'b00; result_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst.busy", busy, 1'b0);
    check("rst.rv", result_valid, 1'b0);
    check_stats("rst", 8'h00, 8'h00, 8'h00, 8'h00);

    // Block 1: 16 x 0x40 back-to-back; result_valid only after the 16th edge.
    pulse_start();
    check("b1.busy", busy, 1'b1);
    check("b1.rv0", result_valid, 1'b0);
    for (int i = 0; i < 15; i++) feed(8'h40, 1'b0);
    check("b1.rv_before_last", result_valid, 1'b0);
    feed(8'h40, 1'b0);
    check("b1.rv_after_last", result_valid, 1'b1);
    check("b1.busy_done", busy, 1'b1);
    check_stats("b1", 8'h40, 8'h40, 8'h40, 8'h00);
    accept_result("b1");
    check_stats("b1.persist", 8'h40, 8'h40, 8'h40, 8'h00);

    // Block 2: ramp 0..15 with a gap after each sample; start pulsed mid-block is ignored.
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (i == 8) start = 1'b1;
      feed(8'(i), (i != 15));
      start = 1'b0;
      if (i < 15) check($sformatf("b2.busy%0d", i), busy, 1'b1);
    end
    check("b2.rv", result_valid, 1'b1);
    check_stats("b2", 8'h07, 8'h00, 8'h0F, 8'h0F);
    accept_result("b2");

    // Block 3: all 0xFF, the largest possible sum.
    pulse_start();
    for (int i = 0; i < 16; i++) feed(8'hFF, 1'b0);
    check("b3.rv", result_valid, 1'b1);
    check_stats("b3", 8'hFF, 8'hFF, 8'hFF, 8'h00);

    // Backpressure: samples and start pulses in DONE change nothing.
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0); sample_valid = 1'b1; sample_in = 8'h11;
      tick();
    end
    start = 1'b0; sample_valid = 1'b0;
    check("bp.rv", result_valid, 1'b1);
    check("bp.busy", busy, 1'b1);
    check_stats("bp", 8'hFF, 8'hFF, 8'hFF, 8'h00);
    // Start in the handshake cycle must not launch a new block.
    start = 1'b1;
    accept_result("bp");
    start = 1'b0;
    tick();
    check("bp.still_idle", busy, 1'b0);

    // Fresh block after backpressure: 0,2,..,30 -> sum 240, avg 15.
    pulse_start();
    for (int i = 0; i < 16; i++) feed(8'(2 * i), 1'b0);
    check("b4.rv", result_valid, 1'b1);
    check_stats("b4", 8'h0F, 8'h00, 8'h1E, 8'h1E);
    accept_result("b4");

    // Reset mid-block after five 0x80 samples.
    pulse_start();
    for (int i = 0; i < 5; i++) feed(8'h80, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr.busy", busy, 1'b0);
    check("mr.rv", result_valid, 1'b0);
    check_stats("mr", 8'h00, 8'h00, 8'h00, 8'h00);
    pulse_start();
    for (int i = 0; i < 16; i++) feed(8'h02, 1'b0);
    check("b5.rv", result_valid, 1'b1);
    check_stats("b5", 8'h02, 8'h02, 8'h02, 8'h00);
    accept_result("b5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_sample_stats.md
Name: tdc_sample_stats

Overview:
- Downstream consumer of the ring-oscillator TDC's 8-bit time-count output.
- Collects a block of 2^LOG2_N count samples and computes their average, plus min/max/range when the optional feature is compiled in.
- Presents one selected 8-bit statistic to the pad-facing output mux, using a valid/ready handshake toward the readout controller.

Parameters:
- LOG2_N, 4, log2 of samples per block; legal range 0..8 (1..256 samples).
- WIDTH, 8, sample and result width; fixed at 8 in this design.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that begins a block; honoured only in IDLE
- sample_in  input  WIDTH  time count from TDC stage
- sample_valid  input  1  sample_in valid this cycle
- stat_sel  input  2  statistic select: 00 avg, 01 min, 10 max, 11 range
- result  output  WIDTH  selected statistic
- result_valid  output  1  block complete; result stable
- result_ready  input  1  consumer accepts result
- busy  output  1  high in ACCUM and DONE

Behaviour:
- Reset (rst=1 at clk edge), from any state including mid-block:
  - state to IDLE.
  - acc, cnt and all stat registers to 0.
  - result_valid=0, busy=0, result=0.
- Registers:
  - acc: WIDTH+LOG2_N bits; cannot overflow.
  - cnt: LOG2_N+1 bits.
  - min_r, max_r: WIDTH bits each.
  - Latched stats: avg_q, min_q, max_q.
- IDLE:
  - busy=0, result_valid=0.
  - On start=1, next cycle: acc=0, cnt=0, min_r=0xFF, max_r=0x00, state to ACCUM.
  - sample_valid is ignored, including on the start cycle.
- ACCUM:
  - busy=1.
  - Each cycle with sample_valid=1: acc+=sample_in; min_r=min(min_r,sample_in); max_r=max(max_r,sample_in); cnt++.
  - The 2^LOG2_N-th accepted sample completes the block. Next cycle: avg_q=(acc+sample)>>LOG2_N (truncating), min_q/max_q take their final values including that sample, state to DONE.
  - Cycles with sample_valid=0 stall without effect.
  - start is ignored.
- DONE:
  - result_valid=1, busy=1.
  - Latched stats hold regardless of sample_valid or start.
  - On result_valid & result_ready: state to IDLE next cycle, result_valid deasserts.
  - A start asserted in that same cycle is ignored; a new block needs start in IDLE.
  - Latched stats persist into IDLE until the next completion.
- result is a combinational mux of the latched stats, registered-source only, so it is glitch-free relative to clk:
  - 00: avg_q
  - 01: min_q
  - 10: max_q
  - 11: max_q-min_q (never negative)
  - stat_sel may change at any time; result follows in the same cycle.
- Latency: result_valid rises exactly 1 cycle after the clock edge that accepts the last sample.
- LOG2_N=0: block = 1 sample; avg=min=max=sample, range=0.

Optional Feature:
- Macro: TDC_STATS_MINMAX_EN.
- Defined: min_r/max_r/min_q/max_q logic is present; stat_sel 01/10/11 behave as above.
- Undefined: min/max registers are not synthesised; stat_sel 01, 10 and 11 return 0x00. avg, handshake and timing are unchanged.

Test Plan:
- LOG2_N=4; start; 16 samples of 0x40 back-to-back -> result_valid 1 cycle after the 16th; avg 0x40, min 0x40, max 0x40, range 0x00.
- Ramp 0..15 with sample_valid gapped every other cycle -> sum 120; avg 0x07, min 0x00, max 0x0F, range 0x0F; busy high throughout.
- 16 samples of 0xFF -> avg 0xFF (acc=4080, no overflow); min=max=0xFF.
- Backpressure: hold result_ready=0 for 10 cycles while driving samples 0x11 and start pulses -> result_valid stays 1, stats unchanged. Raise ready -> IDLE next cycle; a following start runs a fresh block.
- Reset mid-block: rst after 5 samples of 0x80 -> busy=0, result_valid=0, result=0. Next start plus 16 samples of 0x02 -> avg 0x02, with no contribution from the earlier 0x80s.
- Build without TDC_STATS_MINMAX_EN, run the ramp case -> avg 0x07; stat_sel 01/10/11 give 0x00.
